// File: rtl/array_mem_writer.sv
// array_mem_writer: fills the 32x8 array memory from a valid/ready byte
// stream and keeps a running mod-2^DATA_W checksum of the stored words.
// Optional readback pass enabled by `define ARRAY_MEM_WRITER_VERIFY_EN:
// re-reads the loaded words through mem_q and compares their sum with the
// checksum before reporting done.
module array_mem_writer #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] checksum,
    output logic              done,
    output logic              error,
    output logic [2:0]        state
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        VRD   = 3'd2,
        VWAIT = 3'd3,
        VCHK  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sum_q, sum_d;

`ifdef ARRAY_MEM_WRITER_VERIFY_EN
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] vsum_q, vsum_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
`else
    // Read data and read latency only matter to the readback pass.
    logic unused_mem_q;
    assign unused_mem_q = ^{mem_q, WAIT_W'(RD_LATENCY)};
`endif

    assign count    = count_q;
    assign checksum = sum_q;
    assign state    = state_q;

    // State and datapath registers; in_ready/done/error registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            len_q    <= '0;
            sum_q    <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef ARRAY_MEM_WRITER_VERIFY_EN
            rd_cnt_q <= '0;
            vsum_q   <= '0;
            wait_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            len_q    <= len_d;
            sum_q    <= sum_d;
            in_ready <= (state_d == LOAD);
            done     <= (state_d == DONE);
            error    <= (state_d == ERROR);
`ifdef ARRAY_MEM_WRITER_VERIFY_EN
            rd_cnt_q <= rd_cnt_d;
            vsum_q   <= vsum_d;
            wait_q   <= wait_d;
`endif
        end
    end

    // Next-state logic plus the same-cycle memory write/read port drive.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        len_d    = len_q;
        sum_d    = sum_q;
        mem_wren = 1'b0;
        mem_addr = '0;
        mem_data = '0;
`ifdef ARRAY_MEM_WRITER_VERIFY_EN
        rd_cnt_d = rd_cnt_q;
        vsum_d   = vsum_q;
        wait_d   = wait_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        count_d = '0;
                        sum_d   = '0;
                        state_d = DONE;
                    end else if (len <= CNT_W'(DEPTH)) begin
                        len_d   = len;
                        addr_d  = '0;
                        count_d = '0;
                        sum_d   = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end

            LOAD: begin
                mem_addr = addr_q;
                if (in_valid) begin
                    mem_wren = 1'b1;
                    mem_data = in_data;
                    addr_d   = addr_q + ADDR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                    sum_d    = sum_q + in_data;
                    if (count_d == len_q) begin
`ifdef ARRAY_MEM_WRITER_VERIFY_EN
                        rd_cnt_d = '0;
                        vsum_d   = '0;
                        state_d  = VRD;
`else
                        state_d  = DONE;
`endif
                    end
                end
            end

`ifdef ARRAY_MEM_WRITER_VERIFY_EN
            VRD: begin
                mem_addr = rd_cnt_q[ADDR_W-1:0];
                wait_d   = WAIT_W'(RD_LATENCY - 2);
                state_d  = (RD_LATENCY > 1) ? VWAIT : VCHK;
            end

            VWAIT: begin
                mem_addr = rd_cnt_q[ADDR_W-1:0];
                if (wait_q == '0) begin
                    state_d = VCHK;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            VCHK: begin
                mem_addr = rd_cnt_q[ADDR_W-1:0];
                vsum_d   = vsum_q + mem_q;
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                if (rd_cnt_d == len_q) begin
                    state_d = (vsum_d == sum_q) ? DONE : ERROR;
                end else begin
                    state_d = VRD;
                end
            end
`endif

            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end

            ERROR: begin
                state_d = ERROR;
            end

            default: begin
                state_d = ERROR;
            end
        endcase
    end

endmodule

// File: doc/array_mem_writer.md
Name: array_mem_writer

Overview:
- Write-side counterpart to the array-summing loop: an FSM that fills the 32x8 single-port array memory from a valid/ready byte stream (switch entry or testbench).
- Runs a running 8-bit wrap-around checksum that matches the value the summing loop must later produce.
- Sits between the input source and the array_mem write port.
- The summing loop drives the read port afterwards; the top-level muxes the address between the two.

Parameters:
- ADDR_W, 5, memory address width.
- DEPTH, 32, number of words; must equal 2**ADDR_W.
- DATA_W, 8, word width.
- RD_LATENCY, 2, cycles from mem_addr to valid mem_q. Used only with the optional feature.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; begins a load when sampled high in IDLE
- len  in  ADDR_W+1  number of words to write, 0..DEPTH; sampled when start is accepted
- in_valid  in  1  in_data is valid
- in_data  in  DATA_W  word to store (two's complement)
- in_ready  out  1  block accepts a word this cycle
- mem_addr  out  ADDR_W  memory address
- mem_data  out  DATA_W  memory write data
- mem_wren  out  1  memory write enable
- mem_q  in  DATA_W  memory read data (optional feature only)
- count  out  ADDR_W+1  words written so far
- checksum  out  DATA_W  mod-256 sum of the words written
- done  out  1  load complete; held high until start is low
- error  out  1  sticky; cleared only by rst
- state  out  3  current state, for LEDR debug

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - count, checksum, internal addr, len_q = 0.
  - done=0, error=0, in_ready=0, mem_wren=0, mem_addr=0, mem_data=0.
  - mem_wren must drop in the same cycle rst rises, including mid-load.
- States and encodings: IDLE(0), LOAD(1), VRD(2), VWAIT(3), VCHK(4), DONE(5), ERROR(6). Any other encoding goes to ERROR.
- IDLE:
  - in_ready=0.
  - start=1 and len=0: go to DONE; count=0, checksum=0.
  - start=1 and 1<=len<=DEPTH: latch len_q, clear addr/count/checksum, go to LOAD.
  - start=1 and len>DEPTH: go to ERROR.
- LOAD:
  - in_ready=1.
  - Handshake when in_valid & in_ready. In that same cycle (combinational): mem_wren=1, mem_addr=addr, mem_data=in_data.
  - On the next edge: addr+1, count+1, checksum += in_data (mod 256).
  - The last handshake is the one where count+1==len_q. The next state is DONE, or VRD when the feature is enabled. in_ready drops on the following cycle.
  - in_valid low: hold all state; mem_wren=0.
  - Memory latency: zero-cycle write; no back-pressure beyond in_ready.
- DONE:
  - done=1, in_ready=0, mem_wren=0.
  - count and checksum hold.
  - Return to IDLE when start=0. start held high keeps the block in DONE, so there is no auto-restart.
- ERROR:
  - error=1, in_ready=0, mem_wren=0.
  - Stays until rst.
- start is ignored outside IDLE and DONE.
- Address wrap: when len=DEPTH, addr wraps from 31 to 0 after the final write. The wrapped value is unused; count reads 32.
- Checksum uses two's-complement wrap, e.g. 0x7F+0x01=0x80 (displays as -128).
- When the feature is disabled, mem_q is unused and states VRD, VWAIT and VCHK are unreachable.

Optional Feature:
- Macro: ARRAY_MEM_WRITER_VERIFY_EN.
- When defined, a readback pass follows LOAD:
  - VRD: mem_addr=rd_addr (starting at 0), mem_wren=0.
  - VWAIT: wait RD_LATENCY-1 cycles.
  - VCHK: add mem_q into vsum. Increment rd_addr; return to VRD until len_q words have been read.
  - At the end: vsum==checksum goes to DONE; otherwise ERROR.
  - The total pass takes len_q*(RD_LATENCY+1) cycles.
- When undefined: LOAD goes directly to DONE, and mem_q is left unconnected internally.

Test Plan:
- rst pulse then start=1, len=4, stream 5, -3, 10, 1 with in_valid always high -> four mem_wren pulses at addr 0..3 with the same data; checksum=13, count=4, done=1. With the feature: done follows 12 cycles later.
- Same load with in_valid toggling 1,0,1,0,... -> mem_wren only on valid cycles; same final checksum=13; addresses strictly sequential.
- len=32, data 0x7F in every word -> addr 31 written last; count=32; checksum=0x7F*32 mod 256=0xE0 (-32).
- len=0 with start -> DONE the next cycle with no writes; len=33 -> error=1 sticky; start afterwards is ignored until rst.
- rst asserted during the 3rd write of a len=8 load -> mem_wren=0 immediately; state=IDLE; count=0 after release.
- With the feature, bench model corrupts mem_q on address 2 -> error=1 after VCHK; done stays 0.
